// File: rtl/id_pkg.sv
// Shared definitions for the pipelined decode stage: opcodes, EXE commands,
// instruction field positions and the hazard FSM state type.
package id_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_ADDI  = 4'h5,
    OP_SUBI  = 4'h6,
    OP_MOVI  = 4'h7,
    OP_LDR   = 4'h8,
    OP_STR   = 4'h9,
    OP_CMP   = 4'hA,
    OP_B     = 4'hB,
    OP_BEQ   = 4'hC,
    OP_BNE   = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_AND = 4'd3,
    CMD_OR  = 4'd4
  } ex_cmd_e;

  localparam int INSTR_W   = 16;
  localparam int OP_LSB    = 12;
  localparam int RD_LSB    = 8;
  localparam int RA_LSB    = 4;
  localparam int RB_LSB    = 0;
  localparam int FIELD_W   = 4;
  localparam int IMM_W     = 8;
  localparam int OFF_W     = 12;
  localparam int BUB_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LU_STALL   = 2'd1,
    ST_FLAG_STALL = 2'd2
  } hz_state_e;

  // Loads and stores reuse the adder for address generation, CMP uses the subtractor.
  function automatic ex_cmd_e alu_cmd(input opcode_e op);
    case (op)
      OP_SUB, OP_SUBI, OP_CMP: return CMD_SUB;
      OP_AND:                  return CMD_AND;
      OP_OR:                   return CMD_OR;
      default:                 return CMD_ADD;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// ID/EX boundary bus: ID drives the registered op, EXE returns ready.
interface id_stage_pipelined_if #(
  parameter int DATA_W    = 24,
  parameter int RF_ADDR_W = 4
) ();
  logic                 valid;
  logic                 ready;
  logic [3:0]           cmd;
  logic [DATA_W-1:0]    val1;
  logic [DATA_W-1:0]    val2;
  logic [DATA_W-1:0]    st_data;
  logic [RF_ADDR_W-1:0] dest;
  logic                 wb_en;
  logic                 mem_r;
  logic                 mem_w;
  logic                 sets_flag;

  modport master (
    output valid, cmd, val1, val2, st_data, dest, wb_en, mem_r, mem_w, sets_flag,
    input  ready
  );

  modport slave (
    input  valid, cmd, val1, val2, st_data, dest, wb_en, mem_r, mem_w, sets_flag,
    output ready
  );
endinterface

// File: rtl/id_hazard_unit.sv
// Load-use and flag-hazard interlock for the decode stage; raises stall while
// the instruction in IF/ID must not issue.
module id_hazard_unit
  import id_pkg::*;
#(
  parameter int RF_ADDR_W    = 4,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic                 use1,
  input  logic                 use2,
  input  logic [RF_ADDR_W-1:0] src1,
  input  logic [RF_ADDR_W-1:0] src2,
  input  logic                 is_cond_branch,
  input  logic                 ex_valid,
  input  logic                 ex_ready,
  input  logic                 ex_mem_r,
  input  logic                 ex_sets_flag,
  input  logic [RF_ADDR_W-1:0] ex_dest,
  output logic                 stall
);

  hz_state_e            state, state_n;
  logic [BUB_CNT_W-1:0] cnt, cnt_n;
  logic                 lu_hazard;
  logic                 flag_hazard;

  assign lu_hazard = if_valid & ex_valid & ex_mem_r &
                     ((use1 & (src1 == ex_dest)) | (use2 & (src2 == ex_dest)));
  assign flag_hazard = if_valid & is_cond_branch & ex_valid & ex_sets_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The detection cycle already emits the first bubble, so it counts against the budget.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    case (state)
      ST_RUN: begin
        if (lu_hazard) begin
          stall   = 1'b1;
          cnt_n   = ex_ready ? BUB_CNT_W'(LOAD_BUBBLES - 1) : BUB_CNT_W'(LOAD_BUBBLES);
          state_n = (cnt_n == '0) ? ST_RUN : ST_LU_STALL;
        end else if (flag_hazard) begin
          stall   = 1'b1;
          state_n = ST_FLAG_STALL;
        end
      end
      ST_LU_STALL: begin
        stall = (cnt != '0);
        if (ex_ready && (cnt != '0)) begin
          cnt_n = cnt - 1'b1;
        end
        if (cnt_n == '0) begin
          state_n = ST_RUN;
        end
      end
      ST_FLAG_STALL: begin
        stall   = flag_hazard;
        state_n = flag_hazard ? ST_FLAG_STALL : ST_RUN;
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage: decodes the IF/ID instruction, reads the register file, resolves
// branches and feeds a registered ID/EX boundary with valid/ready handshake.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W       = 24,
  parameter int RF_ADDR_W    = 4,
  parameter int LOAD_BUBBLES = 1,
  parameter int PC_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [INSTR_W-1:0]    if_instr,
  input  logic [PC_W-1:0]       if_pc,
  output logic                  id_ready,
  output logic [RF_ADDR_W-1:0]  rf_src1,
  output logic [RF_ADDR_W-1:0]  rf_src2,
  input  logic [DATA_W-1:0]     rf_val1,
  input  logic [DATA_W-1:0]     rf_val2,
  input  logic                  flag_z,
  output logic                  br_taken,
  output logic [PC_W-1:0]       br_target,
  id_stage_pipelined_if.master  ex,
  output logic                  illegal
);

  opcode_e              op;
  logic [RF_ADDR_W-1:0] f_rd, f_ra, f_rb;
  logic [DATA_W-1:0]    imm_sext;
  logic [PC_W-1:0]      off_sext;

  logic                 use1, use2;
  logic                 d_exe, d_branch, d_cond_br, d_br_cond;
  ex_cmd_e              d_cmd;
  logic [DATA_W-1:0]    d_val1, d_val2, d_st;
  logic [RF_ADDR_W-1:0] d_dest;
  logic                 d_wb, d_mr, d_mw, d_sf, d_ill;

  logic                 stall, advance, issue, load_op;

  logic                 ex_valid_q;
  logic [3:0]           ex_cmd_q;
  logic [DATA_W-1:0]    ex_val1_q, ex_val2_q, ex_st_q;
  logic [RF_ADDR_W-1:0] ex_dest_q;
  logic                 ex_wb_q, ex_mr_q, ex_mw_q, ex_sf_q, illegal_q;

  assign op       = opcode_e'(if_instr[OP_LSB +: FIELD_W]);
  assign f_rd     = RF_ADDR_W'(if_instr[RD_LSB +: FIELD_W]);
  assign f_ra     = RF_ADDR_W'(if_instr[RA_LSB +: FIELD_W]);
  assign f_rb     = RF_ADDR_W'(if_instr[RB_LSB +: FIELD_W]);
  assign imm_sext = {{(DATA_W - IMM_W){if_instr[IMM_W-1]}}, if_instr[IMM_W-1:0]};
  assign off_sext = {{(PC_W - OFF_W){if_instr[OFF_W-1]}}, if_instr[OFF_W-1:0]};

  // Unused read ports park at all-ones so the hazard unit can rely on use1/use2 alone.
  always_comb begin
    rf_src1   = '1;
    rf_src2   = '1;
    use1      = 1'b0;
    use2      = 1'b0;
    d_exe     = 1'b1;
    d_branch  = 1'b0;
    d_cond_br = 1'b0;
    d_br_cond = 1'b0;
    d_cmd     = alu_cmd(op);
    d_val1    = '0;
    d_val2    = '0;
    d_st      = '0;
    d_dest    = '0;
    d_wb      = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_sf      = 1'b0;
    d_ill     = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMP: begin
        rf_src1 = f_ra;
        rf_src2 = f_rb;
        use1    = 1'b1;
        use2    = 1'b1;
        d_val1  = rf_val1;
        d_val2  = rf_val2;
        d_sf    = (op == OP_CMP);
        d_wb    = (op != OP_CMP);
        d_dest  = (op != OP_CMP) ? f_rd : '0;
      end
      OP_ADDI, OP_SUBI: begin
        rf_src1 = f_rd;
        use1    = 1'b1;
        d_val1  = rf_val1;
        d_val2  = imm_sext;
        d_wb    = 1'b1;
        d_dest  = f_rd;
      end
      OP_MOVI: begin
        d_val2 = imm_sext;
        d_wb   = 1'b1;
        d_dest = f_rd;
      end
      OP_LDR: begin
        rf_src1 = f_ra;
        use1    = 1'b1;
        d_val1  = rf_val1;
        d_mr    = 1'b1;
        d_wb    = 1'b1;
        d_dest  = f_rd;
      end
      OP_STR: begin
        rf_src1 = f_ra;
        rf_src2 = f_rd;
        use1    = 1'b1;
        use2    = 1'b1;
        d_val1  = rf_val1;
        d_st    = rf_val2;
        d_mw    = 1'b1;
      end
      OP_B, OP_BEQ, OP_BNE: begin
        d_exe     = 1'b0;
        d_branch  = 1'b1;
        d_cond_br = (op != OP_B);
        d_br_cond = (op == OP_B) | ((op == OP_BEQ) ? flag_z : ~flag_z);
      end
      OP_RSV_E, OP_RSV_F: begin
        d_cmd = CMD_NOP;
        d_ill = 1'b1;
      end
      default: begin
        d_cmd = CMD_NOP;
      end
    endcase
  end

  id_hazard_unit #(
    .RF_ADDR_W    (RF_ADDR_W),
    .LOAD_BUBBLES (LOAD_BUBBLES)
  ) u_hazard (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .use1           (use1),
    .use2           (use2),
    .src1           (rf_src1),
    .src2           (rf_src2),
    .is_cond_branch (d_cond_br),
    .ex_valid       (ex_valid_q),
    .ex_ready       (ex.ready),
    .ex_mem_r       (ex_mr_q),
    .ex_sets_flag   (ex_sf_q),
    .ex_dest        (ex_dest_q),
    .stall          (stall)
  );

  assign advance   = ~ex_valid_q | ex.ready;
  assign issue     = if_valid & ~stall & advance;
  assign load_op   = issue & d_exe;
  assign id_ready  = issue | ~if_valid;
  assign br_taken  = issue & d_branch & d_br_cond;
  assign br_target = if_pc + off_sext;

  // Branches and stalls advance the boundary with an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_cmd_q   <= CMD_NOP;
      ex_val1_q  <= '0;
      ex_val2_q  <= '0;
      ex_st_q    <= '0;
      ex_dest_q  <= '0;
      ex_wb_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_mw_q    <= 1'b0;
      ex_sf_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (advance) begin
      if (load_op) begin
        ex_valid_q <= 1'b1;
        ex_cmd_q   <= d_cmd;
        ex_val1_q  <= d_val1;
        ex_val2_q  <= d_val2;
        ex_st_q    <= d_st;
        ex_dest_q  <= d_dest;
        ex_wb_q    <= d_wb;
        ex_mr_q    <= d_mr;
        ex_mw_q    <= d_mw;
        ex_sf_q    <= d_sf;
        illegal_q  <= d_ill;
      end else begin
        ex_valid_q <= 1'b0;
        ex_cmd_q   <= CMD_NOP;
        ex_val1_q  <= '0;
        ex_val2_q  <= '0;
        ex_st_q    <= '0;
        ex_dest_q  <= '0;
        ex_wb_q    <= 1'b0;
        ex_mr_q    <= 1'b0;
        ex_mw_q    <= 1'b0;
        ex_sf_q    <= 1'b0;
        illegal_q  <= 1'b0;
      end
    end
  end

  assign ex.valid     = ex_valid_q;
  assign ex.cmd       = ex_cmd_q;
  assign ex.val1      = ex_val1_q;
  assign ex.val2      = ex_val2_q;
  assign ex.st_data   = ex_st_q;
  assign ex.dest      = ex_dest_q;
  assign ex.wb_en     = ex_wb_q;
  assign ex.mem_r     = ex_mr_q;
  assign ex.mem_w     = ex_mw_q;
  assign ex.sets_flag = ex_sf_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: issued ops go into an expected queue that a
// monitor drains whenever EXE accepts; handshake and branch outputs are checked inline.
module tb_id_stage_pipelined;
  import id_pkg::*;

  localparam int DATA_W = 24;
  localparam int RA_W   = 4;
  localparam int PC_W   = 16;

  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] st;
    logic [RA_W-1:0]   dest;
    logic              wb;
    logic              mr;
    logic              mw;
    logic              sf;
    logic              ill;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [PC_W-1:0]   if_pc;
  logic              id_ready;
  logic [RA_W-1:0]   rf_src1, rf_src2;
  logic [DATA_W-1:0] rf_val1, rf_val2;
  logic              flag_z;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic              illegal;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t act_v, exp_v;

  id_stage_pipelined_if #(.DATA_W(DATA_W), .RF_ADDR_W(RA_W)) ex_bus ();

  id_stage_pipelined #(
    .DATA_W       (DATA_W),
    .RF_ADDR_W    (RA_W),
    .LOAD_BUBBLES (2),
    .PC_W         (PC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .id_ready  (id_ready),
    .rf_src1   (rf_src1),
    .rf_src2   (rf_src2),
    .rf_val1   (rf_val1),
    .rf_val2   (rf_val2),
    .flag_z    (flag_z),
    .br_taken  (br_taken),
    .br_target (br_target),
    .ex        (ex_bus),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [PC_W-1:0] pc,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    rf_val1  = a;
    rf_val2  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [3:0] cmd, input logic [DATA_W-1:0] v1,
                              input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] st,
                              input logic [RA_W-1:0] dest, input logic wb, input logic mr,
                              input logic mw, input logic sf, input logic ill);
    exp_t e;
    e = '{cmd: cmd, val1: v1, val2: v2, st: st, dest: dest, wb: wb, mr: mr, mw: mw, sf: sf, ill: ill};
    return e;
  endfunction

  // One-cycle issue of an instruction that must be accepted immediately.
  task automatic issueOne(input string name, input logic [15:0] instr, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input exp_t e,
                          input logic [RA_W-1:0] s1, input logic [RA_W-1:0] s2);
    applyStimulus(1'b1, instr, 16'h0000, a, b);
    exp_q.push_back(e);
    @(negedge clk);
    checkOutput({name, "_src1"}, 32'(rf_src1), 32'(s1));
    checkOutput({name, "_src2"}, 32'(rf_src2), 32'(s2));
    checkOutput({name, "_id_ready"}, 32'(id_ready), 32'd1);
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0000, 16'h0000, '0, '0);
    tick();
  endtask

  // Monitor: every op EXE accepts must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && ex_bus.valid === 1'b1 && ex_bus.ready === 1'b1) begin
      act_v = '{cmd: ex_bus.cmd, val1: ex_bus.val1, val2: ex_bus.val2, st: ex_bus.st_data,
                dest: ex_bus.dest, wb: ex_bus.wb_en, mr: ex_bus.mem_r, mw: ex_bus.mem_w,
                sf: ex_bus.sets_flag, ill: illegal};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL ex_out: got unexpected op 0x%0h, expected none", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_fail++;
          $display("[TB] FAIL ex_out: got 0x%0h, expected 0x%0h", act_v, exp_v);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    ex_bus.ready = 1'b1;
    flag_z    = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, '0, '0);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_ex_valid", 32'(ex_bus.valid), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_ex_cmd", 32'(ex_bus.cmd), 32'd0);
    checkOutput("rst_ex_wb_en", 32'(ex_bus.wb_en), 32'd0);
    checkOutput("rst_id_ready", 32'(id_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] R-type, immediate, move and store decode");
    issueOne("add", 16'h1123, 24'd5, 24'd7, mk(CMD_ADD, 24'd5, 24'd7, 24'd0, 4'd1, 1, 0, 0, 0, 0), 4'd2, 4'd3);
    issueOne("addi", 16'h53F0, 24'h10, 24'h0, mk(CMD_ADD, 24'h10, 24'hFFFFF0, 24'd0, 4'd3, 1, 0, 0, 0, 0), 4'd3, 4'hF);
    issueOne("movi", 16'h767F, 24'h0, 24'h0, mk(CMD_ADD, 24'h0, 24'h7F, 24'd0, 4'd6, 1, 0, 0, 0, 0), 4'hF, 4'hF);
    issueOne("str", 16'h9520, 24'h100, 24'hABC, mk(CMD_ADD, 24'h100, 24'h0, 24'hABC, 4'd0, 0, 0, 1, 0, 0), 4'd2, 4'd5);
    idle();

    $display("[TB] Load-use interlock with two bubbles");
    issueOne("ldr", 16'h8420, 24'h40, 24'h0, mk(CMD_ADD, 24'h40, 24'h0, 24'd0, 4'd4, 1, 1, 0, 0, 0), 4'd2, 4'hF);
    applyStimulus(1'b1, 16'h1541, 16'h0000, 24'd9, 24'd3);
    @(negedge clk);
    checkOutput("lu_c1_id_ready", 32'(id_ready), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("lu_c2_id_ready", 32'(id_ready), 32'd0);
    checkOutput("lu_c2_ex_valid", 32'(ex_bus.valid), 32'd0);
    tick();
    exp_q.push_back(mk(CMD_ADD, 24'd9, 24'd3, 24'd0, 4'd5, 1, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("lu_c3_id_ready", 32'(id_ready), 32'd1);
    checkOutput("lu_c3_ex_valid", 32'(ex_bus.valid), 32'd0);
    tick();
    idle();

    $display("[TB] Flag hazard on BEQ after CMP");
    issueOne("cmp", 16'hA012, 24'd8, 24'd8, mk(CMD_SUB, 24'd8, 24'd8, 24'd0, 4'd0, 0, 0, 0, 1, 0), 4'd1, 4'd2);
    applyStimulus(1'b1, 16'hCFFD, 16'h0020, '0, '0);
    flag_z = 1'b0;
    @(negedge clk);
    checkOutput("beq_stall_id_ready", 32'(id_ready), 32'd0);
    checkOutput("beq_stall_br_taken", 32'(br_taken), 32'd0);
    tick();
    flag_z = 1'b1;
    @(negedge clk);
    checkOutput("beq_id_ready", 32'(id_ready), 32'd1);
    checkOutput("beq_br_taken", 32'(br_taken), 32'd1);
    checkOutput("beq_br_target", 32'(br_target), 32'h001D);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, '0, '0);
    @(negedge clk);
    checkOutput("beq_bubble_ex_valid", 32'(ex_bus.valid), 32'd0);
    checkOutput("beq_after_br_taken", 32'(br_taken), 32'd0);
    tick();

    $display("[TB] Unconditional and not-taken branches");
    applyStimulus(1'b1, 16'hD005, 16'h0030, '0, '0);
    @(negedge clk);
    checkOutput("bne_id_ready", 32'(id_ready), 32'd1);
    checkOutput("bne_br_taken", 32'(br_taken), 32'd0);
    tick();
    applyStimulus(1'b1, 16'hB010, 16'h0040, '0, '0);
    @(negedge clk);
    checkOutput("b_br_taken", 32'(br_taken), 32'd1);
    checkOutput("b_br_target", 32'(br_target), 32'h0050);
    tick();
    flag_z = 1'b0;
    idle();

    $display("[TB] Reserved opcode");
    issueOne("rsv", 16'hE123, 24'h55, 24'h66, mk(CMD_NOP, 24'h0, 24'h0, 24'd0, 4'd0, 0, 0, 0, 0, 1), 4'hF, 4'hF);
    applyStimulus(1'b0, 16'h0000, 16'h0000, '0, '0);
    @(negedge clk);
    checkOutput("rsv_illegal", 32'(illegal), 32'd1);
    checkOutput("rsv_wb_en", 32'(ex_bus.wb_en), 32'd0);
    checkOutput("rsv_mem_w", 32'(ex_bus.mem_w), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("rsv_cleared", 32'(illegal), 32'd0);
    tick();

    $display("[TB] EXE back-pressure then asynchronous reset");
    applyStimulus(1'b1, 16'h1712, 16'h0000, 24'h11, 24'h22);
    exp_q.push_back(mk(CMD_ADD, 24'h11, 24'h22, 24'd0, 4'd7, 1, 0, 0, 0, 0));
    tick();
    ex_bus.ready = 1'b0;
    applyStimulus(1'b1, 16'h2111, 16'h0000, 24'h99, 24'h98);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_ex_valid", 32'(ex_bus.valid), 32'd1);
      checkOutput("hold_ex_val1", 32'(ex_bus.val1), 32'h11);
      checkOutput("hold_ex_val2", 32'(ex_bus.val2), 32'h22);
      checkOutput("hold_ex_dest", 32'(ex_bus.dest), 32'd7);
      checkOutput("hold_id_ready", 32'(id_ready), 32'd0);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_ex_valid", 32'(ex_bus.valid), 32'd0);
    checkOutput("async_rst_ex_val1", 32'(ex_bus.val1), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    ex_bus.ready = 1'b1;
    idle();

    issueOne("sub", 16'h2234, 24'd20, 24'd6, mk(CMD_SUB, 24'd20, 24'd6, 24'd0, 4'd2, 1, 0, 0, 0, 0), 4'd3, 4'd4);
    applyStimulus(1'b0, 16'h0000, 16'h0000, '0, '0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
